// File: rtl/sme_ks_adder_pipe.sv
// sme_ks_adder_pipe
// Masked (DOM, D-share) Kogge-Stone adder/subtractor with valid/ready handshakes.
// Operands arrive as Boolean shares of a^b' and a&b'. The block runs log2(N)
// prefix stages, one per cycle, and holds the registered shares of the sum
// until the consumer takes them.
//
// Optional feature: define SME_KS_COUT_EN to add port s_cout, which carries
// the shares of the carry-out (bit N of the full sum).
//
// Handshake: a transfer happens on a rising g_clk edge where valid and ready
// are both high. req_ready = IDLE | (DONE & rsp_ready), so a new request can
// be accepted in the same cycle the previous result is consumed.
// rsp_valid stays high and s_rd stays stable until rsp_ready is seen.
module sme_ks_adder_pipe #(
    parameter int D = 3,
    parameter int N = 32,
    localparam int L = $clog2(N),
    localparam int RW = 2 * N * D * (D - 1) / 2
) (
    input  logic           g_clk,
    input  logic           g_reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           sub,
    input  logic [N*D-1:0] s_mxor,
    input  logic [N*D-1:0] s_mand,
    input  logic [RW-1:0]  s_rng,
    output logic           rsp_valid,
    input  logic           rsp_ready,
`ifdef SME_KS_COUT_EN
    output logic [D-1:0]   s_cout,
`endif
    output logic [N*D-1:0] s_rd
);

    // Half of the randomness feeds the p gadgets, the other half the g gadgets.
    localparam int HALF = RW / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [L-1:0]        stage_q, stage_d;   // one-hot prefix stage index
    logic                sub_q, sub_d;
    logic [D-1:0][N-1:0] mxor_q, mxor_d;     // original a^b' shares, needed for the sum
    logic [D-1:0][N-1:0] p_q, p_d;           // group propagate shares
    logic [D-1:0][N-1:0] g_q, g_d;           // group generate shares
    logic [D-1:0][N-1:0] rd_q, rd_d;         // result shares
`ifdef SME_KS_COUT_EN
    logic [D-1:0]        cout_q, cout_d;
`endif

    logic [D-1:0][N-1:0] in_mxor, in_mand;
    logic [D-1:0][N-1:0] ps, gs;             // shifted operands for this stage
    logic [D-1:0][N-1:0] p_run, g_run;       // gadget outputs for this stage
    logic                accept;

    assign in_mxor   = s_mxor;
    assign in_mand   = s_mand;
    assign req_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & rsp_ready);
    assign rsp_valid = (state_q == ST_DONE);
    assign accept    = req_valid & req_ready;
    assign s_rd      = rd_q;
`ifdef SME_KS_COUT_EN
    assign s_cout    = cout_q;
`endif

    // One Kogge-Stone stage as D-share DOM-AND gadgets for p and g; cross terms
    // are blinded with a fresh random bit shared by each pair of domains.
    always_comb begin
        for (int z = 0; z < D; z++) begin
            ps[z] = '0;
            gs[z] = '0;
        end
        for (int k = 0; k < L; k++) begin
            if (stage_q[k]) begin
                for (int z = 0; z < D; z++) begin
                    ps[z] = p_q[z] << (1 << k);
                    gs[z] = g_q[z] << (1 << k);
                end
            end
        end
        // The first stage shifts in a masked constant 1 for p (share 0 only).
        if (stage_q[0]) begin
            ps[0][0] = 1'b1;
        end
        for (int z = 0; z < D; z++) begin
            p_run[z] = p_q[z] & ps[z];
            g_run[z] = g_q[z] ^ (p_q[z] & gs[z]);
        end
        for (int i = 0; i < D; i++) begin
            for (int j = i + 1; j < D; j++) begin
                p_run[i] = p_run[i] ^ (p_q[i] & ps[j])
                         ^ s_rng[(i * (2 * D - i - 1) / 2 + (j - i - 1)) * N +: N];
                p_run[j] = p_run[j] ^ (p_q[j] & ps[i])
                         ^ s_rng[(i * (2 * D - i - 1) / 2 + (j - i - 1)) * N +: N];
                g_run[i] = g_run[i] ^ (p_q[i] & gs[j])
                         ^ s_rng[HALF + (i * (2 * D - i - 1) / 2 + (j - i - 1)) * N +: N];
                g_run[j] = g_run[j] ^ (p_q[j] & gs[i])
                         ^ s_rng[HALF + (i * (2 * D - i - 1) / 2 + (j - i - 1)) * N +: N];
            end
        end
    end

    // Next-state, capture on accept, stage advance and result formation.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        sub_d   = sub_q;
        mxor_d  = mxor_q;
        p_d     = p_q;
        g_d     = g_q;
        rd_d    = rd_q;
`ifdef SME_KS_COUT_EN
        cout_d  = cout_q;
`endif
        case (state_q)
            ST_RUN: begin
                p_d     = p_run;
                g_d     = g_run;
                stage_d = stage_q << 1;
                if (stage_q[L-1]) begin
                    state_d = ST_DONE;
                    stage_d = '0;
                    for (int z = 0; z < D; z++) begin
                        rd_d[z] = mxor_q[z] ^ {g_run[z][N-2:0], 1'b0};
`ifdef SME_KS_COUT_EN
                        cout_d[z] = g_run[z][N-1];
`endif
                    end
                    // The carry-in is public, so it enters share 0 alone.
                    rd_d[0][0] = mxor_q[0][0] ^ sub_q;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept) begin
            state_d = ST_RUN;
            stage_d = {{(L-1){1'b0}}, 1'b1};
            sub_d   = sub;
            mxor_d  = in_mxor;
            p_d     = in_mxor;
            g_d     = in_mand;
            // Fold the carry-in into bit 0 of g; sub is public so each share
            // takes its own share of p[0] and the XOR stays correct.
            for (int z = 0; z < D; z++) begin
                g_d[z][0] = in_mand[z][0] ^ (in_mxor[z][0] & sub);
            end
        end
    end

    // State and share registers; reset clears everything and abandons any op.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            sub_q   <= 1'b0;
            mxor_q  <= '0;
            p_q     <= '0;
            g_q     <= '0;
            rd_q    <= '0;
`ifdef SME_KS_COUT_EN
            cout_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            sub_q   <= sub_d;
            mxor_q  <= mxor_d;
            p_q     <= p_d;
            g_q     <= g_d;
            rd_q    <= rd_d;
`ifdef SME_KS_COUT_EN
            cout_q  <= cout_d;
`endif
        end
    end

endmodule
